rob_multiport: RTL and testbench
================================

ROB_MULTIPORT -- requirements
Module: rob_multiport

Interface
REQ-001 Parameter DEPTH, default 16, number of entries, power of two, 4..64.
REQ-002 Parameter ID_W, default 4, entry-id width, equal to log2(DEPTH).
REQ-003 Parameter NUM_CDB, default 2, number of CDB write ports, 1..4.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; reset when 0 at a rising edge.
REQ-006 flush  in  1  global flush.
REQ-007 rb_valid  in  1; rb_id  in  ID_W  partial rollback; rb_id is the youngest surviving entry.
REQ-008 alloc_valid  in  1; alloc_op  in  5; alloc_rd  in  5; alloc_pc  in  32  allocation request.
REQ-009 alloc_ready  out  1; alloc_id  out  ID_W  acceptance and assigned id (tail).
REQ-010 cdb_valid  in  NUM_CDB; cdb_id  in  NUM_CDB*ID_W; cdb_value  in  NUM_CDB*32  write-back ports.
REQ-011 q1_id/q2_id  in  ID_W; q1_ready/q2_ready  out  1; q1_value/q2_value  out  32  operand queries.
REQ-012 cm_valid  out  2; cm_id  out  2*ID_W; cm_op  out  2*5; cm_rd  out  2*5; cm_value  out  2*32; cm_pc  out  2*32  slot 0 = head, slot 1 = head+1.
REQ-013 cm_ack  in  2  retire per slot.
REQ-014 full, empty  out  1; count  out  ID_W+1  occupancy.
REQ-015 cnt_retired, cnt_branch, cnt_rollback  out  32 each  statistics.

Function
REQ-016 Priority per cycle: rst > flush > rollback > {alloc, CDB, commit}.
REQ-017 alloc_ready = (count < DEPTH) and no rb_valid; no same-cycle credit from commit.
REQ-018 Accepted alloc: entry[tail] busy=1, ready=0, fields stored; tail = tail+1 mod DEPTH.
REQ-019 CDB port k with cdb_valid[k] and busy[cdb_id] sets ready=1, value=cdb_value; non-busy target ignored; same id on two ports: highest k wins.
REQ-020 Query combinational: ready=1 if entry ready or any valid CDB port matches id this cycle (bypass, highest k wins); value from same source.
REQ-021 cm_valid[0] = !empty and ready[head]; cm_valid[1] = cm_valid[0] and count >= 2 and ready[head+1].
REQ-022 Retire count r: 2 if cm_ack==11 and both valid; 1 if cm_ack[0] and cm_valid[0]; else 0; cm_ack[1] without cm_ack[0] ignored.
REQ-023 Retired entries cleared busy/ready; head = head+r mod DEPTH; count = count + alloc - r.
REQ-024 Rollback with busy[rb_id]: entries younger than rb_id cleared; tail = rb_id+1; count = ((rb_id - head) mod DEPTH) + 1 - r; commit in same cycle honoured; CDB to squashed entries dropped.
REQ-025 Rollback with rb_id not busy: ignored entirely.
REQ-026 Flush: head = tail = count = 0, all busy/ready cleared; statistics retained.
REQ-027 full = (count == DEPTH); empty = (count == 0); wrap-around of head/tail is modulo DEPTH.

Reset
REQ-028 rst=0: head, tail, count = 0; all busy/ready = 0; counters = 0; cm_valid = 0; alloc_ready = 1 in the cycle after; value/pc/op payloads not reset.
REQ-029 Reset mid-operation discards all entries without retiring any.

Configuration
REQ-030 Macro ROB_MP_STATS_EN defined: cnt_retired += r; cnt_branch += retired entries with op in ALU_OP_BEQ..ALU_OP_BGEU; cnt_rollback += 1 per honoured rollback; all wrap at 2^32.
REQ-031 Macro undefined: statistics ports remain, driven constant 0, no counter flops.

Verification (DEPTH=8, NUM_CDB=2)
REQ-032 8 allocs, no ack -> alloc_id 0..7, full=1, alloc_ready=0 on 9th cycle, count=8.
REQ-033 ids 0,1 ready, cm_ack=11 -> head 0->2, count 8->6 next cycle; cm_ack=10 -> no retire.
REQ-034 CDB port0 and port1 both id 3 (0xAA, 0xBB) -> value[3]=0xBB; q1_id=3 same cycle -> q1_ready=1, q1_value=0xBB.
REQ-035 head=6, tail=3 (wrapped), rb_id=0 -> tail=1, count=3, entries 1,2 busy=0; concurrent alloc refused.
REQ-036 flush with 5 entries and cnt_retired=7 -> count=0, empty=1, cnt_retired stays 7 (macro on) / 0 (macro off).

Source files
------------

// File: rtl/rob_multiport_if.sv
// Bus bundle for rob_multiport: allocation, CDB write-back, operand queries,
// two-wide commit and occupancy/statistics status.
interface rob_multiport_if #(
  parameter int ID_W    = 4,
  parameter int NUM_CDB = 2
) ();
  logic                    flush;
  logic                    rb_valid;
  logic [ID_W-1:0]         rb_id;
  logic                    alloc_valid;
  logic [4:0]              alloc_op;
  logic [4:0]              alloc_rd;
  logic [31:0]             alloc_pc;
  logic                    alloc_ready;
  logic [ID_W-1:0]         alloc_id;
  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*ID_W-1:0] cdb_id;
  logic [NUM_CDB*32-1:0]   cdb_value;
  logic [ID_W-1:0]         q1_id;
  logic [ID_W-1:0]         q2_id;
  logic                    q1_ready;
  logic                    q2_ready;
  logic [31:0]             q1_value;
  logic [31:0]             q2_value;
  logic [1:0]              cm_valid;
  logic [2*ID_W-1:0]       cm_id;
  logic [9:0]              cm_op;
  logic [9:0]              cm_rd;
  logic [63:0]             cm_value;
  logic [63:0]             cm_pc;
  logic [1:0]              cm_ack;
  logic                    full;
  logic                    empty;
  logic [ID_W:0]           count;
  logic [31:0]             cnt_retired;
  logic [31:0]             cnt_branch;
  logic [31:0]             cnt_rollback;

  modport master (
    output flush, rb_valid, rb_id, alloc_valid, alloc_op, alloc_rd, alloc_pc,
           cdb_valid, cdb_id, cdb_value, q1_id, q2_id, cm_ack,
    input  alloc_ready, alloc_id, q1_ready, q2_ready, q1_value, q2_value,
           cm_valid, cm_id, cm_op, cm_rd, cm_value, cm_pc, full, empty, count,
           cnt_retired, cnt_branch, cnt_rollback
  );

  modport slave (
    input  flush, rb_valid, rb_id, alloc_valid, alloc_op, alloc_rd, alloc_pc,
           cdb_valid, cdb_id, cdb_value, q1_id, q2_id, cm_ack,
    output alloc_ready, alloc_id, q1_ready, q2_ready, q1_value, q2_value,
           cm_valid, cm_id, cm_op, cm_rd, cm_value, cm_pc, full, empty, count,
           cnt_retired, cnt_branch, cnt_rollback
  );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer: multi-port CDB write-back with query bypass, two-wide in-order commit,
// flush and partial rollback. Define ROB_MP_STATS_EN for statistics (branch ops 10..15).
module rob_multiport #(
  parameter int DEPTH   = 16,
  parameter int ID_W    = 4,
  parameter int NUM_CDB = 2
) (
  input logic            clk,
  input logic            rst,
  rob_multiport_if.slave bus
);
  localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);

  logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d, head1, rb_off;
  logic [ID_W:0]    count_q, count_d, surv;
  logic [DEPTH-1:0] busy_q, busy_d, rdy_q, rdy_d;
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      pc_d  [DEPTH];
  logic [4:0]       op_q  [DEPTH];
  logic [4:0]       op_d  [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic             cmv0, cmv1, alloc_fire, rb_hit;
  logic [1:0]       r_raw, r;

  // Bypass wins over stored state; the highest-numbered matching port wins.
  function automatic logic [32:0] query(input logic [ID_W-1:0] qid,
                                        input logic [NUM_CDB-1:0] cv,
                                        input logic [NUM_CDB*ID_W-1:0] cid,
                                        input logic [NUM_CDB*32-1:0] cval);
    logic [32:0] res;
    res = {rdy_q[qid], val_q[qid]};
    for (int k = 0; k < NUM_CDB; k++)
      if (cv[k] && cid[k*ID_W +: ID_W] == qid) res = {1'b1, cval[k*32 +: 32]};
    return res;
  endfunction

  assign head1      = head_q + ID_W'(1);
  assign cmv0       = (count_q != '0) && rdy_q[head_q];
  assign cmv1       = cmv0 && (count_q >= (ID_W+1)'(2)) && rdy_q[head1];
  assign r_raw      = (bus.cm_ack == 2'b11 && cmv1) ? 2'd2 :
                      (bus.cm_ack[0] && cmv0)       ? 2'd1 : 2'd0;
  assign rb_hit     = !bus.flush && bus.rb_valid && busy_q[bus.rb_id];
  assign rb_off     = bus.rb_id - head_q;
  assign surv       = {1'b0, rb_off} + (ID_W+1)'(1);
  // Rolling back to the head leaves one survivor, so at most one entry can retire.
  assign r          = bus.flush ? 2'd0 :
                      (rb_hit && r_raw == 2'd2 && rb_off == '0) ? 2'd1 : r_raw;
  assign alloc_fire = bus.alloc_valid && bus.alloc_ready && !bus.flush;

  always_comb begin
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    val_d   = val_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    head_d  = head_q + ID_W'(r);
    tail_d  = tail_q + ID_W'(alloc_fire);
    count_d = count_q + (ID_W+1)'(alloc_fire) - (ID_W+1)'(r);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus.cdb_valid[k] && busy_q[bus.cdb_id[k*ID_W +: ID_W]]) begin
        rdy_d[bus.cdb_id[k*ID_W +: ID_W]] = 1'b1;
        val_d[bus.cdb_id[k*ID_W +: ID_W]] = bus.cdb_value[k*32 +: 32];
      end
    end
    if (r != 2'd0) begin
      busy_d[head_q] = 1'b0;
      rdy_d[head_q]  = 1'b0;
    end
    if (r == 2'd2) begin
      busy_d[head1] = 1'b0;
      rdy_d[head1]  = 1'b0;
    end
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      rdy_d[tail_q]  = 1'b0;
      op_d[tail_q]   = bus.alloc_op;
      rd_d[tail_q]   = bus.alloc_rd;
      pc_d[tail_q]   = bus.alloc_pc;
    end
    // Squash everything younger than rb_id, measured as age from the head.
    if (rb_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((ID_W'(i) - head_q) > rb_off) begin
          busy_d[i] = 1'b0;
          rdy_d[i]  = 1'b0;
        end
      end
      tail_d  = bus.rb_id + ID_W'(1);
      count_d = surv - (ID_W+1)'(r);
    end
    if (bus.flush) begin
      busy_d  = '0;
      rdy_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      rdy_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
    op_q  <= op_d;
    rd_q  <= rd_d;
    pc_q  <= pc_d;
  end

`ifdef ROB_MP_STATS_EN
  localparam logic [4:0] ALU_OP_BEQ  = 5'd10;
  localparam logic [4:0] ALU_OP_BGEU = 5'd15;

  logic [31:0] cnt_retired_q, cnt_retired_d, cnt_branch_q, cnt_branch_d;
  logic [31:0] cnt_rollback_q, cnt_rollback_d;
  logic        br0, br1;

  assign br0 = (r != 2'd0) && (op_q[head_q] inside {[ALU_OP_BEQ:ALU_OP_BGEU]});
  assign br1 = (r == 2'd2) && (op_q[head1] inside {[ALU_OP_BEQ:ALU_OP_BGEU]});

  always_comb begin
    cnt_retired_d  = cnt_retired_q + 32'(r);
    cnt_branch_d   = cnt_branch_q + 32'(br0) + 32'(br1);
    cnt_rollback_d = cnt_rollback_q + 32'(rb_hit);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_retired_q  <= '0;
      cnt_branch_q   <= '0;
      cnt_rollback_q <= '0;
    end else begin
      cnt_retired_q  <= cnt_retired_d;
      cnt_branch_q   <= cnt_branch_d;
      cnt_rollback_q <= cnt_rollback_d;
    end
  end

  assign bus.cnt_retired  = cnt_retired_q;
  assign bus.cnt_branch   = cnt_branch_q;
  assign bus.cnt_rollback = cnt_rollback_q;
`else
  assign bus.cnt_retired  = '0;
  assign bus.cnt_branch   = '0;
  assign bus.cnt_rollback = '0;
`endif

  assign bus.alloc_ready = (count_q < DEPTH_C) && !bus.rb_valid;
  assign bus.alloc_id    = tail_q;
  assign bus.full        = (count_q == DEPTH_C);
  assign bus.empty       = (count_q == '0);
  assign bus.count       = count_q;
  assign bus.cm_valid    = {cmv1, cmv0};
  assign bus.cm_id       = {head1, head_q};
  assign bus.cm_op       = {op_q[head1], op_q[head_q]};
  assign bus.cm_rd       = {rd_q[head1], rd_q[head_q]};
  assign bus.cm_value    = {val_q[head1], val_q[head_q]};
  assign bus.cm_pc       = {pc_q[head1], pc_q[head_q]};
  assign {bus.q1_ready, bus.q1_value} = query(bus.q1_id, bus.cdb_valid, bus.cdb_id, bus.cdb_value);
  assign {bus.q2_ready, bus.q2_value} = query(bus.q2_id, bus.cdb_valid, bus.cdb_id, bus.cdb_value);
endmodule

// File: tb/tb_rob_multiport.sv
// Self-checking bench for rob_multiport (DEPTH=8, NUM_CDB=2): directed scenarios plus
// randomized traffic against a queue-based reference model of the reorder buffer.
`timescale 1ns/1ps
module tb_rob_multiport;
  localparam int DEPTH = 8;
  localparam int ID_W = 3;
  localparam int NUM_CDB = 2;
  localparam logic [4:0] OP_BEQ = 5'd10;
  localparam logic [4:0] OP_BGEU = 5'd15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_multiport_if #(.ID_W(ID_W), .NUM_CDB(NUM_CDB)) rif ();
  rob_multiport #(.DEPTH(DEPTH), .ID_W(ID_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .bus(rif)
  );

  typedef struct {
    int          id;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_head;
  logic [31:0] m_ret, m_br, m_rb;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] stat(input logic [31:0] x);
`ifdef ROB_MP_STATS_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  function automatic int m_find(input int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  function automatic void m_query(input int qid, output bit rdy, output logic [31:0] val);
    int j;
    j = m_find(qid);
    rdy = 1'b0;
    val = '0;
    if (j >= 0 && mq[j].rdy) begin rdy = 1'b1; val = mq[j].val; end
    for (int k = 0; k < NUM_CDB; k++)
      if (rif.cdb_valid[k] && int'(rif.cdb_id[k*ID_W +: ID_W]) == qid) begin
        rdy = 1'b1; val = rif.cdb_value[k*32 +: 32];
      end
  endfunction

  // Reference behaviour for one rising edge, from the inputs present at that edge.
  function automatic void model_update();
    bit v0, v1, rbh;
    int r, p, j;
    ent_t ne, e;
    if (!rst) begin
      mq.delete(); m_head = 0; m_ret = 0; m_br = 0; m_rb = 0;
      return;
    end
    if (rif.flush) begin mq.delete(); m_head = 0; return; end
    v0 = (mq.size() > 0) && mq[0].rdy;
    v1 = v0 && (mq.size() >= 2) && mq[1].rdy;
    r = (rif.cm_ack == 2'b11 && v1) ? 2 : (rif.cm_ack[0] && v0) ? 1 : 0;
    p = rif.rb_valid ? m_find(int'(rif.rb_id)) : -1;
    rbh = (p >= 0);
    for (int k = 0; k < NUM_CDB; k++) begin
      if (rif.cdb_valid[k]) begin
        j = m_find(int'(rif.cdb_id[k*ID_W +: ID_W]));
        if (j >= 0) begin mq[j].rdy = 1'b1; mq[j].val = rif.cdb_value[k*32 +: 32]; end
      end
    end
    if (rbh) begin
      while (mq.size() > p + 1) void'(mq.pop_back());
      if (r > mq.size()) r = mq.size();
      m_rb = m_rb + 1;
    end else if (rif.alloc_valid && !rif.rb_valid && mq.size() < DEPTH) begin
      ne.id = (m_head + mq.size()) % DEPTH;
      ne.op = rif.alloc_op; ne.rd = rif.alloc_rd; ne.pc = rif.alloc_pc;
      ne.rdy = 1'b0; ne.val = '0;
      mq.push_back(ne);
    end
    for (int i = 0; i < r; i++) begin
      e = mq.pop_front();
      m_ret = m_ret + 1;
      if (e.op >= OP_BEQ && e.op <= OP_BGEU) m_br = m_br + 1;
    end
    m_head = (m_head + r) % DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rif.flush = 0; rif.rb_valid = 0; rif.rb_id = '0;
    rif.alloc_valid = 0; rif.alloc_op = '0; rif.alloc_rd = '0; rif.alloc_pc = '0;
    rif.cdb_valid = '0; rif.cdb_id = '0; rif.cdb_value = '0;
    rif.q1_id = '0; rif.q2_id = '0; rif.cm_ack = '0;
  endtask

  task automatic cdb2(input bit v0, input int id0, input logic [31:0] d0,
                      input bit v1, input int id1, input logic [31:0] d1);
    rif.cdb_valid = {v1, v0};
    rif.cdb_id    = {ID_W'(id1), ID_W'(id0)};
    rif.cdb_value = {d1, d0};
  endtask

  task automatic test_reset();
    rst = 0; idle(); tick(); tick(); rst = 1; #1;
    checks++; if (rif.count !== 4'd0) $display("FAIL reset_count got %0d exp 0", rif.count); else passes++;
    checks++; if (rif.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", rif.empty); else passes++;
    checks++; if (rif.full !== 1'b0) $display("FAIL reset_full got %b exp 0", rif.full); else passes++;
    checks++; if (rif.cm_valid !== 2'b00) $display("FAIL reset_cm_valid got %b exp 00", rif.cm_valid); else passes++;
    checks++; if (rif.alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b exp 1", rif.alloc_ready); else passes++;
    checks++; if (rif.cnt_retired !== 32'd0) $display("FAIL reset_cnt_retired got %0d exp 0", rif.cnt_retired); else passes++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      rif.alloc_valid = 1; rif.alloc_op = 5'(8 + i); rif.alloc_rd = 5'(i + 1);
      rif.alloc_pc = 32'h1000 + 32'(4 * i); #1;
      checks++; if (rif.alloc_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %b exp 1", i, rif.alloc_ready); else passes++;
      checks++; if (rif.alloc_id !== 3'(i)) $display("FAIL fill_id[%0d] got %0d exp %0d", i, rif.alloc_id, i); else passes++;
      tick();
    end
    #1;
    checks++; if (rif.alloc_ready !== 1'b0) $display("FAIL full_alloc_ready got %b exp 0", rif.alloc_ready); else passes++;
    checks++; if (rif.full !== 1'b1) $display("FAIL full_flag got %b exp 1", rif.full); else passes++;
    tick(); idle(); #1;
    checks++; if (rif.count !== 4'd8) $display("FAIL full_count got %0d exp 8", rif.count); else passes++;
  endtask

  task automatic test_commit();
    cdb2(1, 0, 32'h100, 1, 1, 32'h101); tick(); idle(); #1;
    checks++; if (rif.cm_valid !== 2'b11) $display("FAIL commit_valid got %b exp 11", rif.cm_valid); else passes++;
    checks++; if (rif.cm_value !== {32'h101, 32'h100}) $display("FAIL commit_value got %h exp 0000010100000100", rif.cm_value); else passes++;
    checks++; if (rif.cm_pc !== {32'h1004, 32'h1000}) $display("FAIL commit_pc got %h exp 0000100400001000", rif.cm_pc); else passes++;
    rif.cm_ack = 2'b10; tick(); rif.cm_ack = 2'b00; #1;
    checks++; if (rif.count !== 4'd8) $display("FAIL ack10_count got %0d exp 8", rif.count); else passes++;
    rif.cm_ack = 2'b11; tick(); idle(); #1;
    checks++; if (rif.count !== 4'd6) $display("FAIL ack11_count got %0d exp 6", rif.count); else passes++;
    checks++; if (rif.cm_id[ID_W-1:0] !== 3'd2) $display("FAIL ack11_head got %0d exp 2", rif.cm_id[ID_W-1:0]); else passes++;
    checks++; if (rif.cm_valid !== 2'b00) $display("FAIL ack11_valid got %b exp 00", rif.cm_valid); else passes++;
  endtask

  task automatic test_cdb_conflict();
    cdb2(1, 3, 32'hAA, 1, 3, 32'hBB); rif.q1_id = 3'd3; #1;
    checks++; if (rif.q1_ready !== 1'b1) $display("FAIL bypass_ready got %b exp 1", rif.q1_ready); else passes++;
    checks++; if (rif.q1_value !== 32'hBB) $display("FAIL bypass_value got %h exp bb", rif.q1_value); else passes++;
    tick(); idle(); rif.q2_id = 3'd3; #1;
    checks++; if (rif.q2_ready !== 1'b1) $display("FAIL stored_ready got %b exp 1", rif.q2_ready); else passes++;
    checks++; if (rif.q2_value !== 32'hBB) $display("FAIL stored_value got %h exp bb", rif.q2_value); else passes++;
  endtask

  task automatic test_rollback_wrap();
    cdb2(1, 2, 32'h202, 1, 4, 32'h204); tick();
    cdb2(1, 5, 32'h205, 0, 0, 32'h0); tick(); idle();
    rif.cm_ack = 2'b11; tick(); tick(); idle(); #1;
    checks++; if (rif.count !== 4'd2) $display("FAIL wrap_count got %0d exp 2", rif.count); else passes++;
    checks++; if (rif.cm_id[ID_W-1:0] !== 3'd6) $display("FAIL wrap_head got %0d exp 6", rif.cm_id[ID_W-1:0]); else passes++;
    for (int i = 0; i < 3; i++) begin
      rif.alloc_valid = 1; rif.alloc_op = 5'd0; rif.alloc_pc = 32'h2000 + 32'(i); #1;
      checks++; if (rif.alloc_id !== 3'(i)) $display("FAIL wrap_alloc_id[%0d] got %0d exp %0d", i, rif.alloc_id, i); else passes++;
      tick();
    end
    idle();
    rif.rb_valid = 1; rif.rb_id = 3'd0; rif.alloc_valid = 1; #1;
    checks++; if (rif.alloc_ready !== 1'b0) $display("FAIL rb_alloc_ready got %b exp 0", rif.alloc_ready); else passes++;
    tick(); idle(); #1;
    checks++; if (rif.count !== 4'd3) $display("FAIL rb_count got %0d exp 3", rif.count); else passes++;
    checks++; if (rif.alloc_id !== 3'd1) $display("FAIL rb_tail got %0d exp 1", rif.alloc_id); else passes++;
    cdb2(1, 1, 32'h55, 0, 0, 32'h0); tick(); idle();
    rif.q1_id = 3'd1; rif.q2_id = 3'd2; #1;
    checks++; if (rif.q1_ready !== 1'b0) $display("FAIL squashed1_ready got %b exp 0", rif.q1_ready); else passes++;
    checks++; if (rif.q2_ready !== 1'b0) $display("FAIL squashed2_ready got %b exp 0", rif.q2_ready); else passes++;
  endtask

  task automatic test_flush();
    cdb2(1, 6, 32'h606, 0, 0, 32'h0); tick(); idle();
    rif.cm_ack = 2'b01; tick(); idle();
    for (int i = 0; i < 3; i++) begin rif.alloc_valid = 1; tick(); end
    idle(); #1;
    checks++; if (rif.count !== 4'd5) $display("FAIL preflush_count got %0d exp 5", rif.count); else passes++;
    rif.flush = 1; rif.alloc_valid = 1; rif.cm_ack = 2'b11; tick(); idle(); #1;
    checks++; if (rif.count !== 4'd0) $display("FAIL flush_count got %0d exp 0", rif.count); else passes++;
    checks++; if (rif.empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", rif.empty); else passes++;
    checks++; if (rif.cnt_retired !== stat(32'd7)) $display("FAIL flush_cnt_retired got %0d exp %0d", rif.cnt_retired, stat(32'd7)); else passes++;
    checks++; if (rif.cnt_branch !== stat(32'd5)) $display("FAIL flush_cnt_branch got %0d exp %0d", rif.cnt_branch, stat(32'd5)); else passes++;
    checks++; if (rif.cnt_rollback !== stat(32'd1)) $display("FAIL flush_cnt_rollback got %0d exp %0d", rif.cnt_rollback, stat(32'd1)); else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin rif.alloc_valid = 1; tick(); end
    idle(); cdb2(1, 0, 32'h1, 0, 0, 32'h0); tick(); idle();
    rst = 0; rif.cm_ack = 2'b11; tick(); idle(); rst = 1; #1;
    checks++; if (rif.count !== 4'd0) $display("FAIL midreset_count got %0d exp 0", rif.count); else passes++;
    checks++; if (rif.cm_valid !== 2'b00) $display("FAIL midreset_cm_valid got %b exp 00", rif.cm_valid); else passes++;
    checks++; if (rif.cnt_retired !== 32'd0) $display("FAIL midreset_cnt_retired got %0d exp 0", rif.cnt_retired); else passes++;
  endtask

  task automatic test_random();
    bit          e_rdy;
    logic [31:0] e_val;
    bit          v0, v1;
    int          qid;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 399) != 0);
      rif.flush = ($urandom_range(0, 99) == 0);
      rif.rb_valid = ($urandom_range(0, 24) == 0);
      rif.rb_id = 3'($urandom_range(0, DEPTH - 1));
      rif.alloc_valid = ($urandom_range(0, 9) < 6);
      rif.alloc_op = 5'($urandom_range(0, 31));
      rif.alloc_rd = 5'($urandom_range(0, 31));
      rif.alloc_pc = $urandom;
      for (int k = 0; k < NUM_CDB; k++) begin
        rif.cdb_valid[k] = $urandom_range(0, 1) == 1;
        rif.cdb_id[k*ID_W +: ID_W] = 3'((m_head + $urandom_range(0, DEPTH - 1)) % DEPTH);
        rif.cdb_value[k*32 +: 32] = $urandom;
      end
      rif.q1_id = 3'($urandom_range(0, DEPTH - 1));
      rif.q2_id = rif.cdb_id[ID_W-1:0];
      rif.cm_ack = 2'($urandom_range(0, 3));
      #1;
      v0 = (mq.size() > 0) && mq[0].rdy;
      v1 = v0 && (mq.size() >= 2) && mq[1].rdy;
      checks++; if (rif.count !== 4'(mq.size())) $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, rif.count, mq.size()); else passes++;
      checks++; if (rif.full !== (mq.size() == DEPTH) || rif.empty !== (mq.size() == 0)) $display("FAIL rnd_full_empty cyc %0d got %b%b exp %b%b", cyc, rif.full, rif.empty, mq.size() == DEPTH, mq.size() == 0); else passes++;
      checks++; if (rif.alloc_ready !== (mq.size() < DEPTH && !rif.rb_valid)) $display("FAIL rnd_alloc_ready cyc %0d got %b", cyc, rif.alloc_ready); else passes++;
      checks++; if (rif.alloc_id !== 3'((m_head + mq.size()) % DEPTH)) $display("FAIL rnd_alloc_id cyc %0d got %0d exp %0d", cyc, rif.alloc_id, (m_head + mq.size()) % DEPTH); else passes++;
      checks++; if (rif.cm_valid !== {v1, v0}) $display("FAIL rnd_cm_valid cyc %0d got %b exp %b%b", cyc, rif.cm_valid, v1, v0); else passes++;
      checks++; if (rif.cm_id !== {3'((m_head + 1) % DEPTH), 3'(m_head)}) $display("FAIL rnd_cm_id cyc %0d got %h exp head %0d", cyc, rif.cm_id, m_head); else passes++;
      if (v0) begin
        checks++; if ({rif.cm_value[31:0], rif.cm_pc[31:0], rif.cm_op[4:0], rif.cm_rd[4:0]} !== {mq[0].val, mq[0].pc, mq[0].op, mq[0].rd}) $display("FAIL rnd_cm_slot0 cyc %0d got %h/%h exp %h/%h", cyc, rif.cm_value[31:0], rif.cm_pc[31:0], mq[0].val, mq[0].pc); else passes++;
      end
      if (v1) begin
        checks++; if ({rif.cm_value[63:32], rif.cm_pc[63:32], rif.cm_op[9:5], rif.cm_rd[9:5]} !== {mq[1].val, mq[1].pc, mq[1].op, mq[1].rd}) $display("FAIL rnd_cm_slot1 cyc %0d got %h/%h exp %h/%h", cyc, rif.cm_value[63:32], rif.cm_pc[63:32], mq[1].val, mq[1].pc); else passes++;
      end
      for (int qn = 0; qn < 2; qn++) begin
        qid = (qn == 0) ? int'(rif.q1_id) : int'(rif.q2_id);
        m_query(qid, e_rdy, e_val);
        checks++;
        if (((qn == 0) ? rif.q1_ready : rif.q2_ready) !== e_rdy ||
            (e_rdy && ((qn == 0) ? rif.q1_value : rif.q2_value) !== e_val))
          $display("FAIL rnd_query%0d cyc %0d id %0d got %b/%h exp %b/%h", qn + 1, cyc, qid,
                   (qn == 0) ? rif.q1_ready : rif.q2_ready, (qn == 0) ? rif.q1_value : rif.q2_value, e_rdy, e_val);
        else passes++;
      end
      checks++; if ({rif.cnt_retired, rif.cnt_branch, rif.cnt_rollback} !== {stat(m_ret), stat(m_br), stat(m_rb)}) $display("FAIL rnd_stats cyc %0d got %0d/%0d/%0d exp %0d/%0d/%0d", cyc, rif.cnt_retired, rif.cnt_branch, rif.cnt_rollback, stat(m_ret), stat(m_br), stat(m_rb)); else passes++;
      tick();
    end
    rst = 1; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_commit();
    test_cdb_conflict();
    test_rollback_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
